// File: rtl/roic_cfg_pkg.sv
// Shared types and constants for the ROIC configuration sequencer.
// Latency: n/a (types, constants and a pure combinational lookup only).
// Backpressure: n/a.
//
// Contents: FSM state enum, 2-bit step type, the 4-entry register-write
// step table, default timing constants and the per-step payload lookup.
package roic_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT_RSP,
        ST_GAP,
        ST_FINISH
    } state_e;

    typedef logic [1:0] step_t;

    localparam int unsigned TMR_W = 24;
    typedef logic [TMR_W-1:0] tmr_t;

    localparam logic [6:0]  DEF_SLAVE_ADDR  = 7'h74;
    localparam int unsigned DEF_GAP_CYCLES  = 50000;
    localparam int unsigned DEF_MAX_RETRY   = 3;
    localparam int unsigned DEF_RSP_TIMEOUT = 200000;

    localparam step_t LAST_STEP = 2'd3;

    // Register address per step, indexed by step (entry 0 is the LSB byte).
    localparam logic [3:0][7:0] REG_ADDR = {8'h03, 8'h07, 8'h02, 8'h06};
    // Data byte written by the steps that do not carry GPIO bits.
    localparam logic [7:0] CONST_DATA = 8'h00;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } cmd_t;

    // Payload for a step: steps 1 and 3 carry the low/high GPIO byte,
    // steps 0 and 2 write the constant byte.
    function automatic cmd_t step_cmd(input step_t step, input logic [15:0] snap);
        cmd_t c;
        c.reg_addr = REG_ADDR[step];
        case (step)
            2'd1:    c.data = snap[7:0];
            2'd3:    c.data = snap[15:8];
            default: c.data = CONST_DATA;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/roic_cfg_timer.sv
// Loadable 24-bit down-counter with a zero flag, shared by gap and response timeout.
// Latency: loaded value visible the cycle after load_i; decrements once per clock, holds at 0.
// Backpressure: none; load_i always wins over counting.
//
// Ports:
//   clk_i       clock
//   rst_n_i     asynchronous active-low reset (counter -> 0)
//   load_i      load load_val_i on this edge
//   load_val_i  value to load
//   zero_o      counter is 0
module roic_cfg_timer
    import roic_cfg_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic load_i,
    input  tmr_t load_val_i,
    output logic zero_o
);

    tmr_t cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - tmr_t'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/roic_cfg_sequencer.sv
// Issues the fixed 4-step ROIC register-write sequence to the I2C master on start.
// Latency: start -> first cmd_valid 2 clks; GAP_CYCLES idle clks after each response.
// Backpressure: payload held stable while cmd_valid && !cmd_ready; one command in flight.
//
// Ports:
//   s_clk_25mhz, rst_n            clock, async active-low reset
//   cfg_start, gate_gpio_data     start request and GPIO word to snapshot
//   cmd_valid/cmd_ready, cmd_*    command handshake and payload to the I2C master
//   rsp_valid, rsp_nack           transaction-complete strobe and NACK qualifier
//   busy, cfg_done, cfg_err, err_step  status to system control
//
// Optional: define ROIC_CFG_AUTO_EN to start a sequence automatically whenever
// gate_gpio_data differs (in IDLE) from the last successfully sequenced word.
module roic_cfg_sequencer
    import roic_cfg_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR  = DEF_SLAVE_ADDR,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int unsigned MAX_RETRY   = DEF_MAX_RETRY,
    parameter int unsigned RSP_TIMEOUT = DEF_RSP_TIMEOUT
) (
    input  logic        s_clk_25mhz,
    input  logic        rst_n,
    input  logic        cfg_start,
    input  logic [15:0] gate_gpio_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [6:0]  cmd_slave_addr,
    output logic [7:0]  cmd_reg_addr,
    output logic [7:0]  cmd_data,
    input  logic        rsp_valid,
    input  logic        rsp_nack,
    output logic        busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [1:0]  err_step
);

    // The timer flags zero on the last counted cycle, so loads are N-1:
    // GAP spans exactly GAP_CYCLES clocks and the timeout abort is taken on
    // the RSP_TIMEOUT-th WAIT_RSP clock.
    localparam tmr_t       GAP_LOAD  = tmr_t'(GAP_CYCLES - 1);
    localparam tmr_t       RSP_LOAD  = tmr_t'(RSP_TIMEOUT - 1);
    localparam logic [7:0] RETRY_LIM = 8'(MAX_RETRY);

    state_e      state_q, state_d;
    step_t       step_q, step_d;
    logic [7:0]  retry_q, retry_d;
    logic        reissue_q, reissue_d;     // next ISSUE repeats the NACKed step
    logic [15:0] snap_q, snap_d;
    logic        pending_q, pending_d;
    logic        err_pulse_q, err_pulse_d;
    step_t       err_step_q, err_step_d;

    logic        tmr_load;
    tmr_t        tmr_val;
    logic        tmr_zero;
    logic        trig;
    cmd_t        cur_cmd;

`ifdef ROIC_CFG_AUTO_EN
    // Last word that completed a full sequence; only updated on success so
    // a failed value keeps mismatching and is retried.
    logic [15:0] last_q;

    always_ff @(posedge s_clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
        end else if (state_q == ST_FINISH) begin
            last_q <= snap_q;
        end
    end

    assign trig = cfg_start || ((state_q == ST_IDLE) && (gate_gpio_data != last_q));
`else
    assign trig = cfg_start;
`endif

    roic_cfg_timer u_timer (
        .clk_i      (s_clk_25mhz),
        .rst_n_i    (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        retry_d     = retry_q;
        reissue_d   = reissue_q;
        snap_d      = snap_q;
        pending_d   = pending_q;
        err_pulse_d = 1'b0;
        err_step_d  = err_step_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        // Any start seen outside IDLE (including FINISH) is remembered once.
        if (trig && (state_q != ST_IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (trig || pending_q) begin
                    state_d   = ST_LOAD;
                    pending_d = 1'b0;
                end
            end
            ST_LOAD: begin
                snap_d    = gate_gpio_data;
                step_d    = '0;
                retry_d   = '0;
                reissue_d = 1'b0;
                state_d   = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    state_d  = ST_WAIT_RSP;
                    tmr_load = 1'b1;
                    tmr_val  = RSP_LOAD;
                end
            end
            ST_WAIT_RSP: begin
                if (rsp_valid) begin
                    if (!rsp_nack) begin
                        state_d   = ST_GAP;
                        reissue_d = 1'b0;
                        tmr_load  = 1'b1;
                        tmr_val   = GAP_LOAD;
                    end else if (retry_q < RETRY_LIM) begin
                        state_d   = ST_GAP;
                        retry_d   = retry_q + 8'd1;
                        reissue_d = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_val   = GAP_LOAD;
                    end else begin
                        state_d     = ST_IDLE;
                        err_pulse_d = 1'b1;
                        err_step_d  = step_q;
                    end
                end else if (tmr_zero) begin
                    // Timeouts are never retried.
                    state_d     = ST_IDLE;
                    err_pulse_d = 1'b1;
                    err_step_d  = step_q;
                end
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    if (reissue_q) begin
                        reissue_d = 1'b0;
                        state_d   = ST_ISSUE;
                    end else if (step_q == LAST_STEP) begin
                        state_d = ST_FINISH;
                    end else begin
                        step_d  = step_q + step_t'(1);
                        retry_d = '0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge s_clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            retry_q     <= '0;
            reissue_q   <= 1'b0;
            snap_q      <= '0;
            pending_q   <= 1'b0;
            err_pulse_q <= 1'b0;
            err_step_q  <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            retry_q     <= retry_d;
            reissue_q   <= reissue_d;
            snap_q      <= snap_d;
            pending_q   <= pending_d;
            err_pulse_q <= err_pulse_d;
            err_step_q  <= err_step_d;
        end
    end

    // Outputs decode registered state only, so reset clears them at once and
    // the payload (from step_q/snap_q) cannot change while waiting on ready.
    assign cur_cmd        = step_cmd(step_q, snap_q);
    assign cmd_valid      = (state_q == ST_ISSUE);
    assign cmd_slave_addr = cmd_valid ? SLAVE_ADDR       : 7'd0;
    assign cmd_reg_addr   = cmd_valid ? cur_cmd.reg_addr : 8'd0;
    assign cmd_data       = cmd_valid ? cur_cmd.data     : 8'd0;
    assign busy           = (state_q != ST_IDLE);
    assign cfg_done       = (state_q == ST_FINISH);
    assign cfg_err        = err_pulse_q;
    assign err_step       = err_step_q;

endmodule

// File: tb/tb_roic_cfg_sequencer.sv
// Directed bench for roic_cfg_sequencer with short gap/timeout parameters.
// Latency: n/a. Backpressure: bench acts as the I2C master (ready/response).
// Each task drives one scenario and checks hand-computed expectations inline.
module tb_roic_cfg_sequencer;

    localparam int GAP = 5;
    localparam int TO  = 20;
    localparam int MR  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start;
    logic [15:0] gate_gpio_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_slave_addr;
    logic [7:0]  cmd_reg_addr;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic        rsp_nack;
    logic        busy;
    logic        cfg_done;
    logic        cfg_err;
    logic [1:0]  err_step;

    int total = 0;
    int bad   = 0;
    int n_xfer = 0;
    int n_done = 0;
    int n_err  = 0;

    always #5 clk = ~clk;

    roic_cfg_sequencer #(
        .SLAVE_ADDR  (7'h74),
        .GAP_CYCLES  (GAP),
        .MAX_RETRY   (MR),
        .RSP_TIMEOUT (TO)
    ) dut (
        .s_clk_25mhz    (clk),
        .rst_n          (rst_n),
        .cfg_start      (cfg_start),
        .gate_gpio_data (gate_gpio_data),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_slave_addr (cmd_slave_addr),
        .cmd_reg_addr   (cmd_reg_addr),
        .cmd_data       (cmd_data),
        .rsp_valid      (rsp_valid),
        .rsp_nack       (rsp_nack),
        .busy           (busy),
        .cfg_done       (cfg_done),
        .cfg_err        (cfg_err),
        .err_step       (err_step)
    );

    // Event counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) n_xfer++;
        if (cfg_done) n_done++;
        if (cfg_err)  n_err++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    // Master model: wait (bounded) for a command, optionally stall ready,
    // accept it, then optionally return one response strobe.
    task automatic serve(input int hold, input bit nack, input bit respond,
                         output bit got, output logic [6:0] sa,
                         output logic [7:0] ra, output logic [7:0] dt,
                         output int wc, output bit hs_ok);
        wc = 0; got = 1'b0; hs_ok = 1'b1; sa = '0; ra = '0; dt = '0;
        while (!cmd_valid && wc < 200) begin
            tick();
            wc++;
        end
        if (!cmd_valid) return;
        got = 1'b1;
        sa = cmd_slave_addr; ra = cmd_reg_addr; dt = cmd_data;
        repeat (hold) begin
            tick();
            if (cmd_valid !== 1'b1 || cmd_reg_addr !== ra || cmd_data !== dt ||
                cmd_slave_addr !== sa) hs_ok = 1'b0;
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        if (cmd_valid !== 1'b0) hs_ok = 1'b0;
        if (respond) begin
            rsp_valid = 1'b1;
            rsp_nack  = nack;
            tick();
            rsp_valid = 1'b0;
            rsp_nack  = 1'b0;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (cfg_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        total++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_vld_busy: valid=%b busy=%b want 0 0", cmd_valid, busy);
        end
        total++;
        if (cfg_done !== 1'b0 || cfg_err !== 1'b0 || err_step !== 2'd0) begin
            bad++; $display("FAIL reset_status: done=%b err=%b step=%0d want 0 0 0", cfg_done, cfg_err, err_step);
        end
        total++;
        if (cmd_slave_addr !== 7'd0 || cmd_reg_addr !== 8'd0 || cmd_data !== 8'd0) begin
            bad++; $display("FAIL reset_payload: %h %h %h want 0 0 0", cmd_slave_addr, cmd_reg_addr, cmd_data);
        end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        logic [7:0] era [4];
        logic [7:0] ed  [4];
        bit got, ok; logic [6:0] sa; logic [7:0] ra, dt; int wc, n, d0;
        era = '{8'h06, 8'h02, 8'h07, 8'h03};
        ed  = '{8'h00, 8'h5A, 8'h00, 8'hA5};
        d0 = n_done;
        gate_gpio_data = 16'hA55A;
        pulse_start();
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_load: busy=%b want 1", busy); end
        for (int i = 0; i < 4; i++) begin
            serve(0, 1'b0, 1'b1, got, sa, ra, dt, wc, ok);
            total++;
            if (!got || sa !== 7'h74 || ra !== era[i] || dt !== ed[i]) begin
                bad++; $display("FAIL basic_cmd%0d: got=%b addr=%h reg=%h data=%h want 74 %h %h", i, got, sa, ra, dt, era[i], ed[i]);
            end
            total++;
            if (wc != ((i == 0) ? 1 : GAP)) begin
                bad++; $display("FAIL basic_gap%0d: cycles=%0d want %0d", i, wc, (i == 0) ? 1 : GAP);
            end
        end
        wait_done(n);
        total++;
        if (n != GAP || busy !== 1'b1) begin
            bad++; $display("FAIL basic_done: cycles=%0d busy=%b want %0d 1", n, busy, GAP);
        end
        tick();
        total++;
        if (busy !== 1'b0 || cfg_done !== 1'b0 || (n_done - d0) != 1) begin
            bad++; $display("FAIL basic_after: busy=%b done=%b pulses=%0d want 0 0 1", busy, cfg_done, n_done - d0);
        end
    endtask

    task automatic test_ready_stall();
        logic [7:0] era [4];
        logic [7:0] ed  [4];
        bit got, ok; logic [6:0] sa; logic [7:0] ra, dt; int wc, n, x0;
        era = '{8'h06, 8'h02, 8'h07, 8'h03};
        ed  = '{8'h00, 8'h81, 8'h00, 8'h3C};
        x0 = n_xfer;
        gate_gpio_data = 16'h3C81;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            serve((i == 1) ? 7 : 0, 1'b0, 1'b1, got, sa, ra, dt, wc, ok);
            total++;
            if (!got || !ok || ra !== era[i] || dt !== ed[i]) begin
                bad++; $display("FAIL stall_cmd%0d: got=%b stable=%b reg=%h data=%h want 1 1 %h %h", i, got, ok, ra, dt, era[i], ed[i]);
            end
        end
        wait_done(n);
        tick();
        total++;
        if (n != GAP || (n_xfer - x0) != 4 || busy !== 1'b0) begin
            bad++; $display("FAIL stall_end: done_cyc=%0d xfers=%0d busy=%b want %0d 4 0", n, n_xfer - x0, busy, GAP);
        end
    endtask

    task automatic test_nack_retry();
        bit got, ok; logic [6:0] sa; logic [7:0] ra, dt; int wc, n, d0, e0;
        d0 = n_done; e0 = n_err;
        gate_gpio_data = 16'h0F0F;
        pulse_start();
        serve(0, 1'b0, 1'b1, got, sa, ra, dt, wc, ok);
        serve(0, 1'b0, 1'b1, got, sa, ra, dt, wc, ok);
        for (int k = 0; k < 4; k++) begin
            serve(0, (k < 3), 1'b1, got, sa, ra, dt, wc, ok);
            total++;
            if (!got || ra !== 8'h07 || dt !== 8'h00 || wc != GAP) begin
                bad++; $display("FAIL retry_issue%0d: got=%b reg=%h data=%h gap=%0d want 1 07 00 %0d", k, got, ra, dt, wc, GAP);
            end
        end
        serve(0, 1'b0, 1'b1, got, sa, ra, dt, wc, ok);
        total++;
        if (!got || ra !== 8'h03 || dt !== 8'h0F) begin
            bad++; $display("FAIL retry_step3: got=%b reg=%h data=%h want 1 03 0f", got, ra, dt);
        end
        wait_done(n);
        tick();
        total++;
        if ((n_done - d0) != 1 || (n_err - e0) != 0) begin
            bad++; $display("FAIL retry_result: done=%0d err=%0d want 1 0", n_done - d0, n_err - e0);
        end
    endtask

    task automatic test_nack_abort();
        bit got, ok; logic [6:0] sa; logic [7:0] ra, dt; int wc, x0, d0, e0;
        x0 = n_xfer; d0 = n_done; e0 = n_err;
        gate_gpio_data = 16'h55AA;
        pulse_start();
        serve(0, 1'b0, 1'b1, got, sa, ra, dt, wc, ok);
        serve(0, 1'b0, 1'b1, got, sa, ra, dt, wc, ok);
        for (int k = 0; k < 4; k++) begin
            serve(0, 1'b1, 1'b1, got, sa, ra, dt, wc, ok);
        end
        total++;
        if (cfg_err !== 1'b1 || err_step !== 2'd2 || busy !== 1'b0) begin
            bad++; $display("FAIL abort_pulse: err=%b step=%0d busy=%b want 1 2 0", cfg_err, err_step, busy);
        end
        repeat (30) tick();
        total++;
        if ((n_xfer - x0) != 6 || (n_done - d0) != 0 || (n_err - e0) != 1 || err_step !== 2'd2) begin
            bad++; $display("FAIL abort_after: xfers=%0d done=%0d err=%0d step=%0d want 6 0 1 2", n_xfer - x0, n_done - d0, n_err - e0, err_step);
        end
    endtask

    task automatic test_timeout();
        bit got, ok; logic [6:0] sa; logic [7:0] ra, dt; int wc, n;
        gate_gpio_data = 16'h4321;
        pulse_start();
        serve(0, 1'b0, 1'b0, got, sa, ra, dt, wc, ok);
        n = 0;
        while (cfg_err !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (n != TO) begin
            bad++; $display("FAIL timeout_latency: cycles=%0d want %0d", n, TO);
        end
        total++;
        if (err_step !== 2'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL timeout_status: step=%0d busy=%b want 0 0", err_step, busy);
        end
    endtask

    task automatic test_pending();
        logic [7:0] era [8];
        logic [7:0] ed  [8];
        bit got, ok; logic [6:0] sa; logic [7:0] ra, dt; int wc, n, x0, d0;
        era = '{8'h06, 8'h02, 8'h07, 8'h03, 8'h06, 8'h02, 8'h07, 8'h03};
        ed  = '{8'h00, 8'hEF, 8'h00, 8'hBE, 8'h00, 8'h34, 8'h00, 8'h12};
        x0 = n_xfer; d0 = n_done;
        gate_gpio_data = 16'hBEEF;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                pulse_start();
                gate_gpio_data = 16'h1234;
            end
            if (i == 4) begin
                wait_done(n);
                total++;
                if (cfg_done !== 1'b1) begin
                    bad++; $display("FAIL pend_first_done: done=%b want 1", cfg_done);
                end
                pulse_start();  // coincident with FINISH
            end
            serve(0, 1'b0, 1'b1, got, sa, ra, dt, wc, ok);
            total++;
            if (!got || ra !== era[i] || dt !== ed[i]) begin
                bad++; $display("FAIL pend_cmd%0d: got=%b reg=%h data=%h want 1 %h %h", i, got, ra, dt, era[i], ed[i]);
            end
        end
        wait_done(n);
        repeat (30) tick();
        total++;
        if ((n_xfer - x0) != 8 || (n_done - d0) != 2 || busy !== 1'b0) begin
            bad++; $display("FAIL pend_collapse: xfers=%0d done=%0d busy=%b want 8 2 0", n_xfer - x0, n_done - d0, busy);
        end
    endtask

    task automatic test_reset_mid();
        int n, d0, e0;
        gate_gpio_data = 16'h0001;
        pulse_start();
        n = 0;
        while (cmd_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (cmd_valid !== 1'b1) begin bad++; $display("FAIL rstmid_issue: valid=%b want 1", cmd_valid); end
        rst_n = 1'b0;
        #1;
        total++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_async: valid=%b busy=%b want 0 0", cmd_valid, busy);
        end
        d0 = n_done; e0 = n_err;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        total++;
        if ((n_done - d0) != 0 || (n_err - e0) != 0 || busy !== 1'b0 || cmd_valid !== 1'b0 || err_step !== 2'd0) begin
            bad++; $display("FAIL rstmid_after: done=%0d err=%0d busy=%b valid=%b step=%0d want 0 0 0 0 0", n_done - d0, n_err - e0, busy, cmd_valid, err_step);
        end
        // Stray response while idle must be ignored.
        rsp_valid = 1'b1; rsp_nack = 1'b1;
        tick();
        rsp_valid = 1'b0; rsp_nack = 1'b0;
        repeat (5) tick();
        total++;
        if (busy !== 1'b0 || (n_err - e0) != 0 || cmd_valid !== 1'b0) begin
            bad++; $display("FAIL stray_rsp: busy=%b err=%0d valid=%b want 0 0 0", busy, n_err - e0, cmd_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_start = 1'b0;
        gate_gpio_data = 16'h0000;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_nack = 1'b0;
        test_reset();
        test_basic();
        test_ready_stall();
        test_nack_retry();
        test_nack_abort();
        test_timeout();
        test_pending();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/roic_cfg_sequencer.md
Name: roic_cfg_sequencer

Overview:
- Upstream command source for the ROIC I2C master.
- On a start request, snapshots the gate GPIO word and issues a fixed 4-step register-write sequence: reg 0x06←0x00, reg 0x02←gpio[7:0], reg 0x07←0x00, reg 0x03←gpio[15:8].
- Each step is one command on a valid/ready handshake. A programmable gap follows each write. A NACKed step is retried a bounded number of times.
- Reports busy/done/error status to the system control logic.

Parameters:
- SLAVE_ADDR, 7'h74, 7-bit ROIC I2C address placed on every command.
- GAP_CYCLES, 50000, idle clocks after each completed write (2 ms @ 25 MHz); legal range 1..2^24-1.
- MAX_RETRY, 3, re-issues allowed per step after NACK; 0 means no retry.
- RSP_TIMEOUT, 200000, clocks to wait for a response before declaring a timeout error.

Ports:
- s_clk_25mhz  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cfg_start  input  1  single-cycle request to run the sequence
- gate_gpio_data  input  16  gate GPIO configuration word
- cmd_valid  output  1  command offered to the I2C master
- cmd_ready  input  1  I2C master accepts the command
- cmd_slave_addr  output  7  slave address (= SLAVE_ADDR)
- cmd_reg_addr  output  8  ROIC register address
- cmd_data  output  8  register write data
- rsp_valid  input  1  single-cycle transaction-complete strobe from the master
- rsp_nack  input  1  qualifies rsp_valid: 1 = slave NACK
- busy  output  1  sequence in progress
- cfg_done  output  1  single-cycle pulse: all 4 steps ACKed
- cfg_err  output  1  single-cycle pulse: sequence aborted
- err_step  output  2  step index of the last abort (sticky until the next abort)

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - all outputs 0, FSM in IDLE, pending flag cleared.
  - Asserting reset mid-transaction drops cmd_valid immediately. No completion or error pulse is generated.
- FSM states: IDLE, LOAD, ISSUE, WAIT_RSP, GAP, FINISH.
- IDLE:
  - Entered on cfg_start, or on a pending flag set in an earlier cycle.
  - Moves to LOAD and clears pending.
- LOAD (1 clk):
  - Latch gate_gpio_data into snapshot; step=0; retry=0.
  - busy=1 from this cycle until FINISH exits.
- ISSUE:
  - cmd_valid=1; payload driven from step via a lookup on the snapshot.
  - Payload is stable while cmd_valid && !cmd_ready.
  - The transfer occurs on the clock edge where cmd_valid && cmd_ready. cmd_valid deasserts the next cycle and the FSM goes to WAIT_RSP.
  - Minimum ISSUE→WAIT_RSP latency is 1 clk.
- WAIT_RSP:
  - Timeout counter reloads to RSP_TIMEOUT on entry.
  - rsp_valid && !rsp_nack → GAP (gap counter = GAP_CYCLES).
  - rsp_valid && rsp_nack:
    - retry<MAX_RETRY → retry+1, then GAP, then re-ISSUE the same step.
    - otherwise abort.
  - Counter reaching 0 → abort (no retry on timeout).
- GAP:
  - Count down to 0 (exactly GAP_CYCLES clocks), then:
    - if re-issuing after NACK: ISSUE with the same step.
    - else if step==3: FINISH.
    - else: step+1, retry=0, ISSUE.
- FINISH (1 clk):
  - cfg_done=1 for one cycle; busy=0 next cycle; → IDLE.
- Abort:
  - cfg_err=1 for one cycle; err_step=step; busy=0; → IDLE. No further commands are issued.
- Boundary conditions:
  - rsp_valid outside WAIT_RSP is ignored.
  - cfg_start while busy sets pending; multiple starts collapse into one. A new sequence starts on the cycle after FINISH/abort returns to IDLE, with a fresh snapshot.
  - cfg_start coincident with FINISH also sets pending.
  - gate_gpio_data changes during a sequence do not affect it.
  - Step and retry counters never wrap: step saturates at 3 and the FSM leaves before any increment past 3.

Optional Feature:
- ROIC_CFG_AUTO_EN defined:
  - A registered copy of the last sequenced snapshot is compared with gate_gpio_data each clock while in IDLE.
  - Any difference acts as an internal cfg_start. This behaves identically to an external start, including pending-flag rules.
  - The copy updates at cfg_done only, so an aborted value is retried on the next mismatch check.
- ROIC_CFG_AUTO_EN undefined: only cfg_start triggers a sequence; no comparison logic is built.

Decomposition:
- Package roic_cfg_pkg:
  - FSM state enum.
  - Step table constants: REG_ADDR[0..3] = 0x06, 0x02, 0x07, 0x03; constant data bytes.
  - Step width type (2 bits).
  - Default timing constants.
- Sub-module roic_cfg_timer: loadable 24-bit down-counter with zero flag. Shared for the gap and response timeout (only one active at a time).

Test Plan:
- gate_gpio_data=0xA55A, cfg_start, master always ready and ACKs → commands (0x06,0x00), (0x02,0x5A), (0x07,0x00), (0x03,0xA5) in order, all with addr 0x74. Exactly GAP_CYCLES clocks between each response and the next cmd_valid; single cfg_done; busy low afterwards.
- cmd_ready held low 7 clks on step 1 → payload stable for all 7 clks; one transfer only; sequence completes normally.
- NACK on step 2 three times, then ACK (MAX_RETRY=3) → step 2 issued 4 times; cfg_done. With a fourth NACK → cfg_err, err_step=2, no step-3 command.
- No rsp_valid after step 0 transfer → cfg_err exactly RSP_TIMEOUT clks after entering WAIT_RSP; err_step=0.
- cfg_start pulsed twice during a sequence, gate_gpio_data changed to 0x1234 midway → first sequence uses the old snapshot; exactly one follow-up sequence with 0x34/0x12.
- rst_n asserted while cmd_valid=1 → cmd_valid/busy 0 asynchronously; after release, no spurious cfg_done/cfg_err and state is IDLE.
